// File: rtl/i2c_bit_ctrl.sv
// I2C master bit sequencer: splits START/STOP/WRITE/READ into four timed
// quarter-bit phases, drives open-drain enables, handles stretching and arbitration.
module i2c_bit_ctrl #(
    parameter int SIZE = 8
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [SIZE-1:0] QuarterTicks,
    input  logic [1:0]      Cmd,
    input  logic            CmdValid,
    output logic            CmdReady,
    input  logic            TxBit,
    output logic            RxBit,
    output logic            Done,
    output logic            ArbLost,
    input  logic            SclIn,
    input  logic            SdaIn,
    output logic            SclOen,
    output logic            SdaOen,
    output logic            TmrStart,
    output logic            TmrStop,
    output logic [SIZE-1:0] TmrTicks,
    input  logic            TmrOut
);
    localparam logic [2:0] IDLE = 3'd0, PH_A = 3'd1, PH_B = 3'd2, PH_C = 3'd3, PH_D = 3'd4;
    localparam logic [1:0] CMD_START = 2'b00, CMD_STOP = 2'b01, CMD_WRITE = 2'b10, CMD_READ = 2'b11;

    logic [2:0]      state_q, state_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [SIZE-1:0] ticks_q, ticks_d;
    logic            tx_q, tx_d, rx_q, rx_d;
    logic            scl_oen_q, scl_oen_d, sda_oen_q, sda_oen_d;
    logic            done_q, done_d, arb_q, arb_d, ready_q, ready_d, start_q, start_d;
    logic            accept, stretch, adv, arb_loss;

    // {SclOen, SdaOen} to drive while in phase ph of command cmd
    function automatic logic [1:0] phase_oen(input logic [1:0] cmd, input logic [2:0] ph, input logic t);
        logic scl, sda;
        scl = 1'b1;
        sda = 1'b1;
        case (cmd)
            CMD_START: begin scl = (ph != PH_D);                 sda = (ph == PH_A) || (ph == PH_B); end
            CMD_STOP:  begin scl = (ph != PH_A);                 sda = (ph == PH_D); end
            CMD_WRITE: begin scl = (ph == PH_B) || (ph == PH_C); sda = t; end
            default:   begin scl = (ph == PH_B) || (ph == PH_C); sda = 1'b1; end
        endcase
        return {scl, sda};
    endfunction

    assign accept  = CmdValid && ready_q;
    // Slave holding SCL low while we release it freezes the phase timer
    assign stretch = (state_q != IDLE) && scl_oen_q && !SclIn;
    assign adv     = (state_q != IDLE) && TmrOut && !stretch;
    assign arb_loss = adv && !SdaIn &&
                      (((cmd_q == CMD_WRITE) && tx_q && ((state_q == PH_B) || (state_q == PH_C))) ||
                       ((cmd_q == CMD_START) && (state_q == PH_B)));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        ticks_d   = ticks_q;
        rx_d      = rx_q;
        scl_oen_d = scl_oen_q;
        sda_oen_d = sda_oen_q;
        done_d    = 1'b0;
        arb_d     = 1'b0;
        start_d   = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                cmd_d   = Cmd;
                tx_d    = TxBit;
                ticks_d = (QuarterTicks == '0) ? SIZE'(1) : QuarterTicks;
                start_d = 1'b1;
                state_d = PH_A;
                {scl_oen_d, sda_oen_d} = phase_oen(Cmd, PH_A, TxBit);
            end
        end else if (arb_loss) begin
            arb_d     = 1'b1;
            scl_oen_d = 1'b1;
            sda_oen_d = 1'b1;
            state_d   = IDLE;
        end else if (adv) begin
            if ((cmd_q == CMD_READ) && (state_q == PH_C))
                rx_d = SdaIn;
            if (state_q == PH_D) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = state_q + 3'd1;
                {scl_oen_d, sda_oen_d} = phase_oen(cmd_q, state_q + 3'd1, tx_q);
            end
        end
        // Ready only once IDLE has been held for a full cycle
        ready_d = (state_q == IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_START;
            tx_q      <= 1'b0;
            ticks_q   <= '0;
            rx_q      <= 1'b0;
            scl_oen_q <= 1'b1;
            sda_oen_q <= 1'b1;
            done_q    <= 1'b0;
            arb_q     <= 1'b0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tx_q      <= tx_d;
            ticks_q   <= ticks_d;
            rx_q      <= rx_d;
            scl_oen_q <= scl_oen_d;
            sda_oen_q <= sda_oen_d;
            done_q    <= done_d;
            arb_q     <= arb_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
        end
    end

    assign CmdReady = ready_q;
    assign RxBit    = rx_q;
    assign Done     = done_q;
    assign ArbLost  = arb_q;
    assign SclOen   = scl_oen_q;
    assign SdaOen   = sda_oen_q;
    assign TmrStart = start_q;
    assign TmrStop  = (state_q == IDLE) || stretch;
    assign TmrTicks = ticks_q;
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl with a behavioural quarter-bit timer
// and wired-AND SCL/SDA lines.
module tb_i2c_bit_ctrl;
    logic       Clk = 1'b0;
    logic       Rst_n, CmdValid, TxBit;
    logic [1:0] Cmd;
    logic [7:0] QuarterTicks, TmrTicks;
    logic       CmdReady, RxBit, Done, ArbLost, SclIn, SdaIn, SclOen, SdaOen;
    logic       TmrStart, TmrStop, TmrOut;
    logic       scl_hold, sda_pull;
    logic [7:0] t_cnt = 8'd0;
    logic       t_out = 1'b0;
    int         n_chk = 0, n_fail = 0;

    always #5 Clk = ~Clk;

    i2c_bit_ctrl #(.SIZE(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .QuarterTicks(QuarterTicks), .Cmd(Cmd),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .TxBit(TxBit), .RxBit(RxBit),
        .Done(Done), .ArbLost(ArbLost), .SclIn(SclIn), .SdaIn(SdaIn),
        .SclOen(SclOen), .SdaOen(SdaOen), .TmrStart(TmrStart), .TmrStop(TmrStop),
        .TmrTicks(TmrTicks), .TmrOut(TmrOut)
    );

    assign SclIn  = SclOen & ~scl_hold;
    assign SdaIn  = SdaOen & ~sda_pull;
    assign TmrOut = t_out;

    // Quarter-bit timer: load on Start, hold on Stop, pulse every Ticks counting cycles
    always @(posedge Clk) begin
        if (TmrStart) begin
            t_cnt <= TmrTicks;
            t_out <= 1'b0;
        end else if (!TmrStop) begin
            if (t_cnt <= 8'd1) begin
                t_out <= 1'b1;
                t_cnt <= TmrTicks;
            end else begin
                t_cnt <= t_cnt - 8'd1;
                t_out <= 1'b0;
            end
        end else begin
            t_out <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic t, input logic [7:0] q, input int stretch,
                           output int cyc, output logic [7:0] en, output int starts,
                           output logic [7:0] ticks, output int stops, output int dones, output int arbs);
        int ph, rem, w;
        logic prev_out;
        w = 0;
        while (!CmdReady && w < 10) begin
            @(posedge Clk); #1;
            w++;
        end
        Cmd = c; TxBit = t; QuarterTicks = q; CmdValid = 1'b1;
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        cyc = 0; en = 8'h0; starts = 0; ticks = 8'h0; stops = 0; dones = 0; arbs = 0; ph = 0; rem = 0;
        en[7:6] = {SclOen, SdaOen};
        while (cyc < 400) begin
            if (TmrStart) begin
                starts++;
                ticks = TmrTicks;
            end
            #1;
            if (TmrStop) stops++;
            prev_out = TmrOut;
            @(posedge Clk); #1;
            cyc++;
            if (Done) dones++;
            if (ArbLost) arbs++;
            if (Done || ArbLost) break;
            if (rem > 0) begin
                rem--;
                if (rem == 0) scl_hold = 1'b0;
            end
            if (prev_out) begin
                ph++;
                if (ph < 4) en[7-2*ph -: 2] = {SclOen, SdaOen};
                if (ph == 1 && stretch > 0) begin
                    scl_hold = 1'b1;
                    rem = stretch;
                end
            end
        end
        if (dones == 0 && arbs == 0) chk("cmd_timeout", 32'(cyc), 32'd0);
    endtask

    int cyc, starts, stops, dones, arbs, total_done, n;
    logic [7:0] en, ticks;
    logic o;

    initial begin
        Rst_n = 1'b0; CmdValid = 1'b0; Cmd = 2'b00; TxBit = 1'b0; QuarterTicks = 8'd0;
        scl_hold = 1'b0; sda_pull = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_oen", {SclOen, SdaOen}, 2'b11);
        chk("rst_ready", CmdReady, 1'b0);
        chk("rst_stop", TmrStop, 1'b1);
        chk("rst_misc", {Done, ArbLost, RxBit, TmrStart}, 4'b0);
        chk("rst_ticks", TmrTicks, 8'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("ready_after_rst", CmdReady, 1'b1);
        chk("done_after_rst", Done, 1'b0);

        // START, Q=4: Done 4*4+2 cycles after accept with this timer
        run_cmd(2'b00, 1'b0, 8'd4, 0, cyc, en, starts, ticks, stops, dones, arbs);
        chk("start_tstart", 32'(starts), 32'd1);
        chk("start_ticks", ticks, 8'd4);
        chk("start_oen", en, 8'b11_11_10_00);
        chk("start_len", 32'(cyc), 32'd18);
        chk("start_done", 32'(dones), 32'd1);
        @(posedge Clk); #1;
        chk("start_ready_next", CmdReady, 1'b1);
        chk("start_done_pulse", Done, 1'b0);

        // WRITE 0, READ 1, STOP at Q=8
        total_done = 0;
        run_cmd(2'b10, 1'b0, 8'd8, 0, cyc, en, starts, ticks, stops, dones, arbs);
        total_done += dones;
        chk("wr0_oen", en, 8'b00_10_10_00);
        run_cmd(2'b11, 1'b0, 8'd8, 0, cyc, en, starts, ticks, stops, dones, arbs);
        total_done += dones;
        chk("rd_oen", en, 8'b01_11_11_01);
        chk("rd_rx1", RxBit, 1'b1);
        run_cmd(2'b01, 1'b0, 8'd8, 0, cyc, en, starts, ticks, stops, dones, arbs);
        total_done += dones;
        chk("stop_oen", en, 8'b00_10_10_11);
        chk("stop_final", {SclOen, SdaOen}, 2'b11);
        chk("three_done", 32'(total_done), 32'd3);

        // READ of a 0, unstretched reference length
        sda_pull = 1'b1;
        run_cmd(2'b11, 1'b0, 8'd8, 0, cyc, en, starts, ticks, stops, dones, arbs);
        sda_pull = 1'b0;
        chk("rd_rx0", RxBit, 1'b0);
        chk("rd_len", 32'(cyc), 32'd34);
        chk("rd_nostop", 32'(stops), 32'd0);

        // READ stretched by 8 cycles in PH_B
        run_cmd(2'b11, 1'b0, 8'd8, 8, cyc, en, starts, ticks, stops, dones, arbs);
        chk("str_len", 32'(cyc), 32'd42);
        chk("str_stops", 32'(stops), 32'd8);
        chk("str_rx", RxBit, 1'b1);
        chk("str_done", 32'(dones), 32'd1);

        // Arbitration loss: WRITE 1 while another master pulls SDA low
        sda_pull = 1'b1;
        run_cmd(2'b10, 1'b1, 8'd4, 0, cyc, en, starts, ticks, stops, dones, arbs);
        chk("arb_seen", 32'(arbs), 32'd1);
        chk("arb_nodone", 32'(dones), 32'd0);
        chk("arb_len", 32'(cyc), 32'd10);
        chk("arb_oen", {SclOen, SdaOen}, 2'b11);
        sda_pull = 1'b0;
        @(posedge Clk); #1;
        chk("arb_ready", CmdReady, 1'b1);
        chk("arb_pulse", ArbLost, 1'b0);
        chk("arb_tstop", TmrStop, 1'b1);

        // QuarterTicks=0 clamps to 1
        run_cmd(2'b10, 1'b1, 8'd0, 0, cyc, en, starts, ticks, stops, dones, arbs);
        chk("q0_ticks", ticks, 8'd1);
        chk("q0_len", 32'(cyc), 32'd6);
        chk("q0_oen", en, 8'b01_11_11_01);
        chk("q0_done", 32'(dones), 32'd1);

        // Reset in PH_C of a START
        @(posedge Clk); #1;
        Cmd = 2'b00; QuarterTicks = 8'd4; CmdValid = 1'b1;
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            o = TmrOut;
            @(posedge Clk); #1;
            if (o) n++;
        end
        chk("phc_reached", {SclOen, SdaOen}, 2'b10);
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        chk("midrst_oen", {SclOen, SdaOen}, 2'b11);
        chk("midrst_stop", TmrStop, 1'b1);
        chk("midrst_misc", {CmdReady, Done, TmrStart}, 3'b000);
        chk("midrst_ticks", TmrTicks, 8'd0);
        Rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (Done) n++;
        end
        chk("midrst_nodone", 32'(n), 32'd0);
        chk("midrst_ready", CmdReady, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
